// File: rtl/reg_muldiv_unit.sv
// reg_muldiv_unit: iterative 32-bit multiply/divide unit beside the register file.
// Reads operands through ports A/B, runs WIDTH shift-add or restoring-division
// steps, then writes the result through port C with a one-cycle done pulse.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies stop once the remaining
// multiplier bits are zero, and divide-by-zero skips EXEC entirely.
module reg_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] addra,
  input  logic [WIDTH-1:0]  dataa,
  output logic [ADDR_W-1:0] addrb,
  input  logic [WIDTH-1:0]  datab,
  output logic              enc,
  output logic [ADDR_W-1:0] addrc,
  output logic [WIDTH-1:0]  datac,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  // hi/lo hold product upper:lower halves, or remainder:quotient for division.
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                enc_q, enc_d, done_q, done_d, busy_q, busy_d;
  logic [ADDR_W-1:0]   addrc_q, addrc_d;
  logic [WIDTH-1:0]    datac_q, datac_d;
  logic [WIDTH:0]      sum_s, shifted_s, diff_s;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W:0]      shamt_s;
  logic [WIDTH-1:0]    rem_bits_s;
`endif

  assign addra = rs1_q;
  assign addrb = rs2_q;
  assign enc   = enc_q;
  assign addrc = addrc_q;
  assign datac = datac_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // Next-state, datapath step and registered-output computation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    enc_d     = 1'b0;
    done_d    = 1'b0;
    addrc_d   = {ADDR_W{1'b0}};
    datac_d   = {WIDTH{1'b0}};
    sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    shifted_s = {hi_q, lo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, b_q};
`ifdef MULDIV_EARLY_OUT_EN
    shamt_s    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    rem_bits_s = lo_q & ~({WIDTH{1'b1}} << shamt_s);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          op_d    = op;
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        a_d     = dataa;
        b_d     = datab;
        hi_d    = {WIDTH{1'b0}};
        lo_d    = op_q[1] ? dataa : datab;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = S_EXEC;
`ifdef MULDIV_EARLY_OUT_EN
        if (op_q[1] && (datab == {WIDTH{1'b0}})) begin
          hi_d    = dataa;
          lo_d    = {WIDTH{1'b1}};
          state_d = S_WRITE;
        end else begin
          state_d = S_EXEC;
        end
`endif
      end
      S_EXEC: begin
        if (!op_q[1]) begin
          hi_d = sum_s[WIDTH:1];
          lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
        end else if (!diff_s[WIDTH]) begin
          hi_d = diff_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
`ifdef MULDIV_EARLY_OUT_EN
        // No multiplier bits left: the remaining steps are pure shifts.
        if (!op_q[1] && (rem_bits_s == {WIDTH{1'b0}})) begin
          {hi_d, lo_d} = {hi_q, lo_q} >> shamt_s;
          state_d      = S_WRITE;
        end else begin
          cnt_d = cnt_d;
        end
`endif
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are loaded on the edge that enters WRITE so they are valid
    // for exactly that cycle.
    if ((state_d == S_WRITE) && (state_q != S_WRITE)) begin
      done_d  = 1'b1;
      enc_d   = (rd_q != {ADDR_W{1'b0}});
      addrc_d = rd_q;
      case (op_q)
        OP_MUL:   datac_d = lo_d;
        OP_MULHU: datac_d = hi_d;
        OP_DIVU:  datac_d = lo_d;
        OP_REMU:  datac_d = hi_d;
        default:  datac_d = {WIDTH{1'b0}};
      endcase
    end else begin
      done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any pending operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      rs1_q   <= {ADDR_W{1'b0}};
      rs2_q   <= {ADDR_W{1'b0}};
      rd_q    <= {ADDR_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      enc_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      addrc_q <= {ADDR_W{1'b0}};
      datac_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      addrc_q <= addrc_d;
      datac_q <= datac_d;
    end
  end

endmodule

// File: tb/tb_reg_muldiv_unit.sv
// Self-checking bench for reg_muldiv_unit: directed cases plus random
// operations compared against plain-arithmetic reference results.
module tb_reg_muldiv_unit;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic [ADDR_W-1:0] addra, addrb, addrc;
  logic [WIDTH-1:0]  dataa, datab, datac;
  logic              enc, busy, done;

  logic [WIDTH-1:0]  regs [32];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                enc_cnt  = 0;

  reg_muldiv_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .addra(addra), .dataa(dataa), .addrb(addrb), .datab(datab),
    .enc(enc), .addrc(addrc), .datac(datac), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  assign dataa = regs[addra];
  assign datab = regs[addrb];

  // Count every write-enable pulse seen by the register file.
  always @(posedge clock) begin
    if (enc === 1'b1) enc_cnt <= enc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the cycle start is driven until done is visible.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int bl;
    bl = 0;
    if (o[1]) return (b == 32'd0) ? 2 : WIDTH + 2;
    for (int k = 0; k < 32; k++) if (b[k]) bl = k + 1;
    return (3 + bl < WIDTH + 2) ? 3 + bl : WIDTH + 2;
`else
    return WIDTH + 2;
`endif
  endfunction

  // Issue one operation at a negedge and check its write-back. When poke is
  // set, a second start with a different rd/op is pulsed while busy.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [31:0] va, input logic [31:0] vb,
                        input bit poke);
    int n;
    int e0;
    logic [31:0] exp_v;
    int lat;
    regs[s1] = va;
    regs[s2] = vb;
    exp_v = ref_res(o, regs[s1], regs[s2]);
    lat   = exp_lat(o, regs[s2]);
    e0    = enc_cnt;
    op = o; rs1 = s1; rs2 = s2; rd = d; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
      end
      if (poke && n == 5) begin
        start = 1'b1; rd = 5'd11; op = ~o; rs1 = s2; rs2 = s1;
      end
      if (poke && n == 6) start = 1'b0;
    end
    chk("latency", n, lat);
    chk("enc_in_write", {31'd0, enc}, {31'd0, (d != 5'd0)});
    chk("addrc", {27'd0, addrc}, {27'd0, d});
    chk("datac", datac, exp_v);
    chk("busy_in_write", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("enc_one_cycle", {31'd0, enc}, 32'd0);
    chk("enc_count", enc_cnt - e0, (d != 5'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int e0;
    logic [1:0]  r_op;
    logic [31:0] r_b;
    reset = 1'b1; start = 1'b0; op = 2'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_enc", {31'd0, enc}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addra", {27'd0, addra}, 32'd0);
    chk("rst_datac", datac, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: basic multiply
    run_op(2'd0, 5'd1, 5'd2, 5'd3, 32'd7, 32'd6, 1'b0);
    // 2: high and low halves
    run_op(2'd1, 5'd1, 5'd2, 5'd4, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(2'd0, 5'd1, 5'd2, 5'd5, 32'hFFFF_FFFF, 32'd2, 1'b0);
    // 3: back-to-back divide/remainder
    run_op(2'd2, 5'd1, 5'd2, 5'd6, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 5'd1, 5'd2, 5'd7, 32'd100, 32'd7, 1'b0);
    // 4: divide by zero
    run_op(2'd2, 5'd1, 5'd2, 5'd6, 32'd100, 32'd0, 1'b0);
    run_op(2'd3, 5'd1, 5'd2, 5'd7, 32'd100, 32'd0, 1'b0);

    // 5: reset in the middle of EXEC
    regs[1] = 32'd123; regs[2] = 32'd456;
    op = 2'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    e0 = enc_cnt;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_enc", {31'd0, enc}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("midrst_no_write", enc_cnt - e0, 32'd0);
    run_op(2'd0, 5'd1, 5'd2, 5'd8, 32'd3, 32'd5, 1'b0);

    // 6: rd=0 suppresses the write; start while busy is ignored
    run_op(2'd0, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 1'b0);
    run_op(2'd0, 5'd1, 5'd2, 5'd10, 32'd11, 32'd13, 1'b1);

    // Randomised operations
    for (int i = 0; i < 12; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i == 5) r_b = 32'd0;
      run_op(r_op, 5'($urandom_range(1, 15)), 5'($urandom_range(16, 31)),
             5'($urandom_range(0, 31)), $urandom, r_b, (i == 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
